// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch-to-decode queue.
package fetch_pkg;

    localparam int AW    = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle: master is the fetch/decode environment,
// slave is the queue itself.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int AW = fetch_pkg::AW
) ();

    logic [AW-1:0] PCF;
    logic [AW-1:0] InstrF;
    logic          FlushD;
    logic          StallD;
    logic          pc_en;
    logic          validD;
    logic [AW-1:0] InstrD;
    logic [AW-1:0] PCD;
    logic [AW-1:0] PCPlus4D;
    logic [31:0]   bubble_cnt;

    modport master (
        output PCF, InstrF, FlushD, StallD,
        input  pc_en, validD, InstrD, PCD, PCPlus4D, bubble_cnt
    );

    modport slave (
        input  PCF, InstrF, FlushD, StallD,
        output pc_en, validD, InstrD, PCD, PCPlus4D, bubble_cnt
    );

endinterface

// File: rtl/fetch_fifo_mem.sv
// Entry storage for the fetch queue: one write port, one asynchronous
// read port, cleared on reset so no stale entry survives.
module fetch_fifo_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = fetch_pkg::DEPTH,
    parameter int W     = 2 * fetch_pkg::AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Register array write; whole array cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue. Captures {PCF, InstrF} each cycle the
// PC register advances, presents the oldest entry to decode, halts fetch
// when full and drops everything on a redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = fetch_pkg::DEPTH,
    parameter int AW    = fetch_pkg::AW
) (
    input  logic         clk,
    input  logic         rst,
    fetch_queue_if.slave fq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Same layout as fetch_entry_t, but sized by this instance's AW.
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] instr;
    } entry_t;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          valid, deq, enq;
    entry_t        wr_entry, head;

    // Handshake: control depends only on registered state and FlushD/StallD,
    // never on InstrF.
    assign valid = (count != '0);
    assign deq   = valid & ~fq.StallD;
    assign enq   = ~fq.FlushD & ((count < CW'(DEPTH)) | deq);

    assign fq.pc_en  = fq.FlushD | enq;
    assign fq.validD = valid;

    assign wr_entry = '{pc: fq.PCF, instr: fq.InstrF};

    fetch_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (2 * AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Head outputs are zeroed whenever the queue is empty.
    assign fq.InstrD   = valid ? head.instr : '0;
    assign fq.PCD      = valid ? head.pc : '0;
    assign fq.PCPlus4D = valid ? head.pc + AW'(4) : '0;

    // Pointer/occupancy update; a flush empties the queue and wins over
    // any coincident dequeue (enq is already suppressed by FlushD).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (fq.FlushD) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    // Count every cycle decode sees no valid instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       fq.bubble_cnt <= '0;
        else if (!valid) fq.bubble_cnt <= fq.bubble_cnt + 32'd1;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: an in-bench PC register feeds the queue,
// expected decoded entries go into a scoreboard queue and a monitor pops
// and compares them whenever decode actually consumes the head.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.AW(32)) fq ();

    fetch_queue #(.DEPTH(2), .AW(32)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]  pc;
    logic         en_seen;
    fetch_entry_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic drive_pc();
        fq.PCF    = pc;
        fq.InstrF = ~pc;
    endtask

    task automatic push_exp(input logic [31:0] p);
        fetch_entry_t e;
        e.pc    = p;
        e.instr = ~p;
        exp_q.push_back(e);
    endtask

    // One cycle: apply controls, sample pc_en mid-cycle, then advance the
    // bench's PC register after the edge exactly as a real PC register would.
    task automatic step(input logic fl, input logic st, input logic [31:0] tgt);
        fq.FlushD = fl;
        fq.StallD = st;
        @(negedge clk);
        en_seen = fq.pc_en;
        @(posedge clk);
        #1;
        if (en_seen) pc = fl ? tgt : pc + 32'd4;
        drive_pc();
    endtask

    // Scoreboard monitor: decode consumes the head when valid, not stalled
    // and not being flushed.
    always @(negedge clk) begin
        if (rst && fq.validD && !fq.StallD && !fq.FlushD) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry: got pc %0h want none", fq.PCD);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                chk("head_pc", fq.PCD, e.pc);
                chk("head_instr", fq.InstrD, e.instr);
                chk("head_pcplus4", fq.PCPlus4D, e.pc + 32'd4);
            end
        end
    end

    initial begin
        pc = '0;
        drive_pc();
        fq.FlushD = 1'b0;
        fq.StallD = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_validD", {31'd0, fq.validD}, 32'd0);
        chk("rst_PCD", fq.PCD, 32'd0);
        chk("rst_PCPlus4D", fq.PCPlus4D, 32'd0);
        chk("rst_pc_en", {31'd0, fq.pc_en}, 32'd1);
        chk("rst_bubble", fq.bubble_cnt, 32'd0);
        rst = 1'b1;

        // Free run: 0,4,8,C consumed in cycles 1..4
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("run_pc_en", {31'd0, en_seen}, 32'd1);
            if (i == 0) begin
                chk("run_validD_c1", {31'd0, fq.validD}, 32'd1);
                chk("run_PCD_c1", fq.PCD, 32'h0);
            end
            if (i == 2) begin
                chk("run_PCD_c3", fq.PCD, 32'h8);
                chk("run_PCPlus4D_c3", fq.PCPlus4D, 32'hC);
            end
        end
        chk("run_bubble", fq.bubble_cnt, 32'd1);

        // Stall 5 cycles with 0x10 at head; fills on the first, halts fetch after
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 32'h0);
            chk("stall_pc_en", {31'd0, en_seen}, (i == 0) ? 32'd1 : 32'd0);
            chk("stall_PCD", fq.PCD, 32'h10);
        end

        // Release: 0x10,0x14,0x18 back to back, full queue keeps pc_en high
        push_exp(32'h10); push_exp(32'h14); push_exp(32'h18);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("release_pc_en", {31'd0, en_seen}, 32'd1);
        end
        chk("full_before_flush_PCD", fq.PCD, 32'h1C);

        // Flush while full, target 0x100: one bubble, old entries never seen
        step(1'b1, 1'b0, 32'h100);
        chk("flush_pc_en", {31'd0, en_seen}, 32'd1);
        chk("flush_validD", {31'd0, fq.validD}, 32'd0);
        chk("flush_PCD_zero", fq.PCD, 32'd0);
        chk("flush_InstrD_zero", fq.InstrD, 32'd0);
        chk("flush_PCPlus4D_zero", fq.PCPlus4D, 32'd0);
        push_exp(32'h100);
        step(1'b0, 1'b0, 32'h0);
        chk("target_PCD", fq.PCD, 32'h100);
        chk("target_bubble", fq.bubble_cnt, 32'd2);
        step(1'b0, 1'b0, 32'h0);
        chk("pre_flush2_PCD", fq.PCD, 32'h104);

        // Flush and dequeue together with one entry: exactly one more bubble
        step(1'b1, 1'b0, 32'h200);
        chk("flush2_validD", {31'd0, fq.validD}, 32'd0);
        chk("flush2_bubble", fq.bubble_cnt, 32'd2);
        step(1'b0, 1'b0, 32'h0);
        chk("flush2_PCD", fq.PCD, 32'h200);
        chk("flush2_bubble_after", fq.bubble_cnt, 32'd3);

        // Fill to two entries, then assert reset mid-cycle
        step(1'b0, 1'b1, 32'h0);
        chk("fill_validD", {31'd0, fq.validD}, 32'd1);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        #2;
        rst = 1'b0;
        fq.StallD = 1'b0;
        pc = '0;
        drive_pc();
        #1;
        chk("arst_validD", {31'd0, fq.validD}, 32'd0);
        chk("arst_PCD", fq.PCD, 32'd0);
        chk("arst_InstrD", fq.InstrD, 32'd0);
        chk("arst_PCPlus4D", fq.PCPlus4D, 32'd0);
        chk("arst_bubble", fq.bubble_cnt, 32'd0);
        chk("arst_pc_en", {31'd0, fq.pc_en}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Flush every third cycle over 1024 cycles: bubbles = flushes + 1
        push_exp(32'h0);
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] tgt;
            tgt = 32'h1000 + ((i / 3) << 4);
            if (i % 3 == 2) push_exp(tgt);
            step(i % 3 == 2, 1'b0, tgt);
            chk("loop_pc_en", {31'd0, en_seen}, 32'd1);
        end
        chk("loop_bubble", fq.bubble_cnt, 32'd342);
        chk("loop_last_PCD", fq.PCD, 32'h2540);
        step(1'b0, 1'b0, 32'h0);
        chk("loop_scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Fetch-to-decode instruction queue, directly downstream of the PC register. Each cycle it captures the fetch-stage pair {PCF, InstrF} into a small FIFO and presents the oldest entry to decode. It drives the PC register's enable so fetch halts when the queue is full. It absorbs decode stalls without dropping instructions and discards wrong-path entries on a branch flush.

## Interface
- `DEPTH`, default 2: number of queue entries; power of two, ≥2.
- `AW`, default 32: width of PC and instruction words.

Ports:
- `clk` input, 1: rising-edge clock.
- `rst` input, 1: asynchronous, active-low reset (asserted when 0).
- `PCF` input, AW: PC currently held by the PC register.
- `InstrF` input, AW: instruction-memory read data for `PCF`; combinational, valid in the same cycle.
- `FlushD` input, 1: branch/jump redirect; discard all queued entries.
- `StallD` input, 1: decode cannot accept the head entry this cycle.
- `pc_en` output, 1: enable to the PC register.
- `validD` output, 1: head entry is valid.
- `InstrD` output, AW: head instruction.
- `PCD` output, AW: head PC.
- `PCPlus4D` output, AW: `PCD + 4`, modulo 2^AW.
- `bubble_cnt` output, 32: count of cycles with `validD=0` since reset; wraps at 2^32.

## Operation
- State:
  - storage `mem[DEPTH]` of {pc, instr};
  - `wr_ptr` and `rd_ptr`, log2(DEPTH) bits each, wrapping naturally;
  - `count`, 0..DEPTH.
- Combinational handshake terms:
  - `deq = validD & ~StallD`
  - `enq = ~FlushD & ((count < DEPTH) | deq)`
  - `pc_en = FlushD | enq`, so the PC loads the redirect target in the flush cycle.
- `validD = (count != 0)`.
- Head outputs `InstrD`, `PCD` and `PCPlus4D` come from `mem[rd_ptr]` when valid. They are forced to 0 when `validD=0`; `PCPlus4D` is then also 0.
- Clock edge, no flush:
  - if `enq`: write {PCF, InstrF} at `wr_ptr`, then `wr_ptr+1`;
  - if `deq`: `rd_ptr+1`;
  - `count` += `enq` − `deq`.
- Clock edge, `FlushD=1`:
  - `count←0` and `rd_ptr←wr_ptr`;
  - no write occurs;
  - any coincident `deq` has no further effect (flush wins).
- Full with simultaneous dequeue: enqueue and dequeue both occur, `count` is unchanged, and `pc_en=1`. This sustains one instruction per cycle.
- Full with `StallD=1`: `enq=0` and `pc_en=0`. `PCF`/`InstrF` are held by the stopped PC register, so nothing is lost.
- `bubble_cnt` increments on every edge at which `validD=0`, including flush-recovery cycles.

## Timing
- Reset (`rst=0`, asynchronous):
  - `count`, `wr_ptr`, `rd_ptr`, `mem` and `bubble_cnt` go to 0;
  - outputs go to `validD=0`, `InstrD=PCD=PCPlus4D=0`, `bubble_cnt=0`;
  - `pc_en=1`, since `count<DEPTH` and no flush.
- Reset release is synchronous to the next rising edge. The first enqueue happens at the first edge with `rst=1`.
- Reset asserted mid-operation: all entries are discarded immediately; no partial state survives.
- Latency: {PCF, InstrF} sampled at edge N appears on `InstrD`/`PCD` in cycle N+1 if the queue was empty. Otherwise it appears after the older entries drain.
- After a flush at edge N:
  - queue is empty in cycle N+1 (`validD=0`);
  - target instruction is enqueued at edge N+1;
  - target is visible in cycle N+2.
  - Result: exactly one bubble per redirect.
- `pc_en` and `validD` depend only on current-cycle inputs and registered state. There is no combinational path from `InstrF` to any control output.

## Structure
- Shared package `fetch_pkg`:
  - `AW`;
  - `DEPTH`;
  - `typedef struct packed {logic [AW-1:0] pc; logic [AW-1:0] instr;} fetch_entry_t`.
- One sub-module, `fetch_fifo_mem`: DEPTH×entry register array with one write port and one asynchronous read port, reset to zero.
- Pointers, count, handshake and `bubble_cnt` live in `fetch_queue`.

## Test plan
- Reset then free-run with `PCF` = 0,4,8,…, `StallD=0`:
  - `validD` rises in cycle 1;
  - `PCD` = 0,4,8 on consecutive cycles;
  - `PCPlus4D = PCD+4`;
  - `pc_en` stays 1;
  - `bubble_cnt=1`.
- `StallD=1` for 5 cycles starting with `PCD=0x10`:
  - queue fills to 2 and `pc_en=0` from the second stalled cycle;
  - `PCD` holds 0x10;
  - on release, `PCD` = 0x10, 0x14, 0x18 back-to-back with no gap or duplicate.
- `FlushD` pulse while full, target 0x100:
  - `pc_en=1` in the flush cycle;
  - `validD=0` the next cycle;
  - `PCD=0x100` one cycle later;
  - the old entries never appear.
- Flush and dequeue in the same cycle with `count=1`: count becomes 0 and no write occurs; `bubble_cnt` increments by exactly 1.
- Assert `rst=0` asynchronously mid-cycle with the queue full: all outputs go to 0 before the next edge, `pc_en=1`, and the pointers restart at 0.
- Hold `StallD=0` with repeated flushes every 3rd cycle for 2^10 cycles: the pointers wrap correctly, and `bubble_cnt` equals the number of flushes plus 1.
